// File: rtl/data_mux2.sv
`timescale 1ns/1ps
// data_mux2 -- N-bit two-input data multiplexer with an optional registered,
// valid/ready-handshaked output stage backed by a two-entry skid buffer.
//
// Ports:
//   clk, rst_n       clock (rising edge) and asynchronous active-low reset
//   in1, in2         data sources; control = 0 selects in1, 1 selects in2
//   control          select bit
//   out              combinational selection (zero latency, ignores handshake)
//   in_valid         capture {in1, in2, control} into the buffer this cycle
//   in_ready         buffer has room (decoded from registered occupancy only)
//   out_q, out_sel   head entry of the buffer: selected data and its select bit
//   out_valid        head entry is valid
//   out_ready        consumer takes the head entry this cycle
module data_mux2 #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] in1,
  input  logic [N-1:0] in2,
  input  logic         control,
  output logic [N-1:0] out,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N-1:0] out_q,
  output logic         out_sel,
  output logic         out_valid,
  input  logic         out_ready
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

  occ_e         state_q, state_d;
  logic [N-1:0] head_data, tail_data;
  logic         head_sel, tail_sel;
  logic         push, pop;

  // Zero-latency path; the registered stage captures exactly this value.
  assign out = control ? in2 : in1;

  // Handshake flags decode only the occupancy register, so in_ready never
  // depends combinationally on out_ready.
  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign out_q   = head_data;
  assign out_sel = head_sel;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  // NOTE: state_d is defaulted first so no path through the case can leave
  // it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: if (push) state_d = ONE;
      ONE: begin
        if (push && !pop)      state_d = FULL;
        else if (pop && !push) state_d = EMPTY;
      end
      FULL:    if (pop) state_d = ONE;
      default: state_d = EMPTY;
    endcase
  end

  // Head always holds the oldest entry; tail is only meaningful when FULL.
  // NOTE: both entries are reset as well, since out_q/out_sel must read 0
  // straight after reset even though they are flagged invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_data <= '0;
      head_sel  <= 1'b0;
      tail_data <= '0;
      tail_sel  <= 1'b0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (push) begin
            head_data <= out;
            head_sel  <= control;
          end
        end
        ONE: begin
          // Push with pop: the old head leaves, so the new entry is head.
          if (push && pop) begin
            head_data <= out;
            head_sel  <= control;
          end else if (push) begin
            tail_data <= out;
            tail_sel  <= control;
          end
        end
        FULL: begin
          if (pop) begin
            head_data <= tail_data;
            head_sel  <= tail_sel;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mux2.sv
`timescale 1ns/1ps
module tb_data_mux2;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] in1, in2;
  logic         control;
  logic [N-1:0] out;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] out_q;
  logic         out_sel;
  logic         out_valid;
  logic         out_ready;

  typedef struct {
    logic [N-1:0] data;
    logic         sel;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  data_mux2 #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in1       (in1),
    .in2       (in2),
    .control   (control),
    .out       (out),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_q     (out_q),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a pop happens on the next rising edge whenever out_valid &&
  // out_ready; inputs are stable between edges, so sample on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("sb_underflow", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("sb_data", 32'(out_q), 32'(e.data));
          check("sb_sel", 32'(out_sel), 32'(e.sel));
        end
      end
    end
  end

  // Present one vector with in_valid held until it is captured, then drop
  // in_valid just after the capture edge. exp_d is hand-computed.
  task automatic drive(input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic c, input logic [N-1:0] exp_d);
    int waited = 0;
    exp_t e;
    in1 = a; in2 = b; control = c; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && waited < 20) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) begin
      check("drive_timeout", 32'd0, 32'd1);
    end else begin
      e.data = exp_d; e.sel = c;
      sb_q.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [N-1:0] tp_a [4];
  logic [N-1:0] tp_b [4];
  logic         tp_c [4];
  logic [N-1:0] tp_e [4];

  initial begin
    tp_a = '{8'd1, 8'd200, 8'd33, 8'd255};
    tp_b = '{8'd2, 8'd100, 8'd44, 8'd0};
    tp_c = '{1'b0, 1'b1, 1'b1, 1'b0};
    tp_e = '{8'd1, 8'd100, 8'd44, 8'd255};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in1 = 8'd0; in2 = 8'd0; control = 1'b0;
    #3;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_q", 32'(out_q), 32'd0);
    check("rst_out_sel", 32'(out_sel), 32'd0);

    // Combinational path, no clock edge required.
    in1 = 8'd22; in2 = 8'd14; control = 1'b0; #1;
    check("comb_in1", 32'(out), 32'd22);
    in1 = 8'd70; in2 = 8'd17; control = 1'b1; #1;
    check("comb_in2", 32'(out), 32'd17);
    control = 1'b0; #1;
    check("comb_toggle", 32'(out), 32'd70);

    step();
    rst_n = 1'b1;

    // Single registered transfer.
    out_ready = 1'b1;
    drive(8'd22, 8'd14, 1'b0, 8'd22);
    check("single_valid", 32'(out_valid), 32'd1);
    check("single_q", 32'(out_q), 32'd22);
    check("single_sel", 32'(out_sel), 32'd0);
    step();
    check("single_drain", 32'(out_valid), 32'd0);

    // Backpressure fills to FULL; order must be preserved.
    out_ready = 1'b0;
    drive(8'd70, 8'd17, 1'b1, 8'd17);
    check("bp_one_ready", 32'(in_ready), 32'd1);
    drive(8'd22, 8'd14, 1'b0, 8'd22);
    check("bp_full_ready", 32'(in_ready), 32'd0);
    check("bp_full_q", 32'(out_q), 32'd17);
    // in_valid while FULL must be ignored.
    in1 = 8'd99; in2 = 8'd98; control = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("bp_ignore_q", 32'(out_q), 32'd17);
    check("bp_ignore_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    step();
    check("bp_pop1_q", 32'(out_q), 32'd22);
    check("bp_pop1_sel", 32'(out_sel), 32'd0);
    check("bp_pop1_ready", 32'(in_ready), 32'd1);
    step();
    check("bp_empty", 32'(out_valid), 32'd0);

    // Simultaneous push and pop in ONE.
    out_ready = 1'b0;
    drive(8'd70, 8'd17, 1'b1, 8'd17);
    out_ready = 1'b1;
    drive(8'd9, 8'd5, 1'b1, 8'd5);
    check("pp_valid", 32'(out_valid), 32'd1);
    check("pp_ready", 32'(in_ready), 32'd1);
    check("pp_q", 32'(out_q), 32'd5);
    step();
    check("pp_drain", 32'(out_valid), 32'd0);

    // Back-to-back throughput with out_ready held high.
    for (int i = 0; i < 4; i++) begin
      exp_t e;
      in1 = tp_a[i]; in2 = tp_b[i]; control = tp_c[i]; in_valid = 1'b1;
      @(negedge clk);
      check("tp_ready", 32'(in_ready), 32'd1);
      e.data = tp_e[i]; e.sel = tp_c[i];
      sb_q.push_back(e);
      step();
    end
    in_valid = 1'b0;
    check("tp_last_q", 32'(out_q), 32'd255);
    step();
    check("tp_drain", 32'(out_valid), 32'd0);

    // Asynchronous reset while FULL.
    out_ready = 1'b0;
    drive(8'd70, 8'd17, 1'b1, 8'd17);
    drive(8'd22, 8'd14, 1'b0, 8'd22);
    check("ar_full", 32'(in_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    sb_q.delete();
    #1;
    check("ar_valid", 32'(out_valid), 32'd0);
    check("ar_ready", 32'(in_ready), 32'd1);
    check("ar_q", 32'(out_q), 32'd0);
    check("ar_sel", 32'(out_sel), 32'd0);
    in1 = 8'd3; in2 = 8'd4; control = 1'b1; #1;
    check("ar_comb", 32'(out), 32'd4);
    step();
    rst_n = 1'b1;
    // First capture on the first edge after release.
    out_ready = 1'b1;
    drive(8'd11, 8'd12, 1'b0, 8'd11);
    check("post_rst_q", 32'(out_q), 32'd11);
    step();
    step();
    check("sb_left", sb_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
